// File: rtl/i2s_tx_fifo.sv
// ============================================================================
// i2s_tx_fifo
// ----------------------------------------------------------------------------
// Stereo serial-audio transmitter with an internal frame FIFO.
//
// The sample source pushes stereo frames over a valid/ready handshake. The
// serial side generates MCLK, BCLK and LRCLK from in_clk and shifts each frame
// out MSB-first in I2S, left-justified or right-justified format. The format
// is chosen at run time and only takes effect while the interface is idle.
// A frame start that finds the FIFO empty sends silence and raises a
// one-cycle underrun pulse.
//
// Parameters
//   BPS         sample width in bits per channel (1..SLOT)
//   SLOT        BCLK periods per channel slot (I2S needs SLOT >= BPS+1)
//   BCLK_DIV    in_clk cycles per BCLK half-period (>= 2)
//   MCLK_DIV    in_clk cycles per MCLK half-period (>= 1)
//   FIFO_DEPTH  stereo frames buffered (power of 2, >= 2)
//
// Ports
//   in_clk        system clock
//   in_rst_n      asynchronous active-low reset; aborts any frame, flushes FIFO
//   in_en         1 = run serial interface, 0 = stop at next frame boundary
//   in_mode       0 = I2S, 1 = left-justified, 2 = right-justified, 3 = as LJ
//   in_valid      in_left/in_right hold a frame
//   in_left       left sample, two's complement
//   in_right      right sample, two's complement
//   out_ready     FIFO can accept a frame (registered)
//   out_level     number of frames currently held in the FIFO
//   out_underrun  one-cycle pulse when a frame start found the FIFO empty
//   out_MCLK      codec master clock
//   out_BLCK      bit clock
//   out_PBLRC     playback LR clock
//   out_PBDAT     playback serial data
//   out_MUTE      codec mute, active low (1 = unmuted)
// ============================================================================
module i2s_tx_fifo #(
    parameter int BPS        = 24,
    parameter int SLOT       = 32,
    parameter int BCLK_DIV   = 24,
    parameter int MCLK_DIV   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                in_clk,
    input  logic                                in_rst_n,
    input  logic                                in_en,
    input  logic [1:0]                          in_mode,
    input  logic                                in_valid,
    input  logic [BPS-1:0]                      in_left,
    input  logic [BPS-1:0]                      in_right,
    output logic                                out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     out_level,
    output logic                                out_underrun,
    output logic                                out_MCLK,
    output logic                                out_BLCK,
    output logic                                out_PBLRC,
    output logic                                out_PBDAT,
    output logic                                out_MUTE
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    localparam int LW  = $clog2(FIFO_DEPTH + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = $clog2(2 * SLOT);
    localparam int BCW = $clog2(BCLK_DIV);
    localparam int MCW = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;

    localparam logic [1:0] MODE_I2S = 2'd0;
    localparam logic [1:0] MODE_RJ  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [BPS-1:0] mem_left  [FIFO_DEPTH];
    logic [BPS-1:0] mem_right [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic [LW-1:0]  level_next;
    logic           ready_q;

    state_t         state;
    logic [1:0]     mode_q;
    logic [BCW-1:0] bclk_div_cnt;
    logic [MCW-1:0] mclk_div_cnt;
    logic [BW-1:0]  bit_idx;
    logic [BPS-1:0] left_q;
    logic [BPS-1:0] right_q;

    logic           mclk_q;
    logic           bclk_q;
    logic           pblrc_q;
    logic           pbdat_q;
    logic           mute_q;
    logic           underrun_q;

    // ------------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------------
    logic           running;
    logic           bclk_tick;
    logic           bclk_fall;
    logic           bclk_rise;
    logic           frame_edge;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           underrun_evt;

    // bit_idx always names the bit that the next BCLK falling edge presents,
    // so a falling edge with bit_idx == 0 is a frame start.
    assign running      = (state != IDLE);
    assign bclk_tick    = running && (bclk_div_cnt == BCW'(BCLK_DIV - 1));
    assign bclk_fall    = bclk_tick && bclk_q;
    assign bclk_rise    = bclk_tick && !bclk_q;
    assign frame_edge   = bclk_fall && (bit_idx == '0);
    assign fifo_empty   = (level == '0);
    assign push         = in_valid && ready_q;
    // No bypass: an empty FIFO at frame start underruns even if a push lands
    // in the same cycle. STOP never pops; it leaves at this edge instead.
    assign pop          = frame_edge && (state == RUN) && !fifo_empty;
    assign underrun_evt = frame_edge && (state == RUN) && fifo_empty;

    // ------------------------------------------------------------------------
    // FIFO occupancy
    // ------------------------------------------------------------------------
    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (!push && pop) begin
            level_next = level - LW'(1);
        end
    end

    // Pointers rely on FIFO_DEPTH being a power of two for natural wrap.
    // out_ready is registered from the next level so it never depends
    // combinationally on in_valid.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level   <= level_next;
            ready_q <= (level_next != LW'(FIFO_DEPTH));
        end
    end

    // Frame storage needs no reset; the pointers define what is valid.
    always_ff @(posedge in_clk) begin
        if (push) begin
            mem_left[wr_ptr]  <= in_left;
            mem_right[wr_ptr] <= in_right;
        end
    end

    // ------------------------------------------------------------------------
    // Serial bit selection
    // ------------------------------------------------------------------------
    logic           right_ch;
    logic [31:0]    k_pos;
    logic [31:0]    shamt;
    logic           bit_live;
    logic [BPS-1:0] cur_sample;
    logic           data_bit;
    logic           lr_bit;

    always_comb begin
        right_ch = (32'(bit_idx) >= 32'(SLOT));
        k_pos    = right_ch ? (32'(bit_idx) - 32'(SLOT)) : 32'(bit_idx);

        // At frame start the hold registers still carry the previous frame,
        // so the first left bit comes straight from the FIFO head.
        if (bit_idx == '0) begin
            cur_sample = fifo_empty ? '0 : mem_left[rd_ptr];
        end else begin
            cur_sample = right_ch ? right_q : left_q;
        end

        bit_live = 1'b0;
        shamt    = '0;
        case (mode_q)
            MODE_I2S: begin
                if ((k_pos >= 32'd1) && (k_pos <= 32'(BPS))) begin
                    bit_live = 1'b1;
                    shamt    = 32'(BPS) - k_pos;
                end
            end
            MODE_RJ: begin
                if (k_pos >= 32'(SLOT - BPS)) begin
                    bit_live = 1'b1;
                    shamt    = 32'(SLOT - 1) - k_pos;
                end
            end
            default: begin
                if (k_pos < 32'(BPS)) begin
                    bit_live = 1'b1;
                    shamt    = 32'(BPS - 1) - k_pos;
                end
            end
        endcase

        data_bit = bit_live && (|(cur_sample & (BPS'(1) << shamt)));
        lr_bit   = (mode_q == MODE_I2S) ? right_ch : !right_ch;
    end

    // ------------------------------------------------------------------------
    // Control FSM, clock generation and serial outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state        <= IDLE;
            mode_q       <= MODE_I2S;
            bclk_div_cnt <= '0;
            mclk_div_cnt <= '0;
            bit_idx      <= '0;
            left_q       <= '0;
            right_q      <= '0;
            mclk_q       <= 1'b0;
            bclk_q       <= 1'b1;
            pblrc_q      <= 1'b1;
            pbdat_q      <= 1'b0;
            mute_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            underrun_q <= underrun_evt;

            case (state)
                IDLE: begin
                    // MCLK holds its last level while idle.
                    mode_q       <= in_mode;
                    bclk_q       <= 1'b1;
                    pblrc_q      <= 1'b1;
                    pbdat_q      <= 1'b0;
                    mute_q       <= 1'b0;
                    bclk_div_cnt <= '0;
                    mclk_div_cnt <= '0;
                    bit_idx      <= '0;
                    if (in_en) begin
                        state <= RUN;
                    end
                end

                RUN, STOP: begin
                    if (mclk_div_cnt == MCW'(MCLK_DIV - 1)) begin
                        mclk_div_cnt <= '0;
                        mclk_q       <= !mclk_q;
                    end else begin
                        mclk_div_cnt <= mclk_div_cnt + MCW'(1);
                    end

                    if (bclk_tick) begin
                        bclk_div_cnt <= '0;
                    end else begin
                        bclk_div_cnt <= bclk_div_cnt + BCW'(1);
                    end

                    if ((state == STOP) && frame_edge) begin
                        // The edge that would begin a new frame instead parks
                        // the interface; BCLK stays high rather than falling.
                        state   <= IDLE;
                        bclk_q  <= 1'b1;
                        pblrc_q <= 1'b1;
                        pbdat_q <= 1'b0;
                        mute_q  <= 1'b0;
                    end else begin
                        mute_q <= 1'b1;
                        if (bclk_rise) begin
                            bclk_q <= 1'b1;
                        end
                        if (bclk_fall) begin
                            bclk_q  <= 1'b0;
                            pbdat_q <= data_bit;
                            pblrc_q <= lr_bit;
                            if (bit_idx == BW'(2 * SLOT - 1)) begin
                                bit_idx <= '0;
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                            end
                        end
                        if (frame_edge) begin
                            left_q  <= fifo_empty ? '0 : mem_left[rd_ptr];
                            right_q <= fifo_empty ? '0 : mem_right[rd_ptr];
                        end
                        if ((state == RUN) && !in_en) begin
                            state <= STOP;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_ready    = ready_q;
    assign out_level    = level;
    assign out_underrun = underrun_q;
    assign out_MCLK     = mclk_q;
    assign out_BLCK     = bclk_q;
    assign out_PBLRC    = pblrc_q;
    assign out_PBDAT    = pbdat_q;
    assign out_MUTE     = mute_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// ============================================================================
// tb_i2s_tx_fifo
// ----------------------------------------------------------------------------
// Directed self-checking bench for i2s_tx_fifo with BCLK_DIV=2, MCLK_DIV=1,
// BPS=24, SLOT=32, FIFO_DEPTH=4. One BCLK period is four in_clk cycles.
// Serial data and LRCLK are captured at BCLK rising edges; the first rising
// edge after entering RUN carries bit 0 of the frame. Captured bits are
// shifted in so the first bit ends up most significant.
// ============================================================================
module tb_i2s_tx_fifo;

    localparam int BPS        = 24;
    localparam int SLOT       = 32;
    localparam int BCLK_DIV   = 2;
    localparam int MCLK_DIV   = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(FIFO_DEPTH + 1);

    logic           in_clk   = 1'b0;
    logic           in_rst_n = 1'b1;
    logic           in_en    = 1'b0;
    logic [1:0]     in_mode  = 2'd0;
    logic           in_valid = 1'b0;
    logic [BPS-1:0] in_left  = '0;
    logic [BPS-1:0] in_right = '0;

    logic           out_ready;
    logic [LW-1:0]  out_level;
    logic           out_underrun;
    logic           out_MCLK;
    logic           out_BLCK;
    logic           out_PBLRC;
    logic           out_PBDAT;
    logic           out_MUTE;

    int checks = 0;
    int passed = 0;

    i2s_tx_fifo #(
        .BPS        (BPS),
        .SLOT       (SLOT),
        .BCLK_DIV   (BCLK_DIV),
        .MCLK_DIV   (MCLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .in_clk       (in_clk),
        .in_rst_n     (in_rst_n),
        .in_en        (in_en),
        .in_mode      (in_mode),
        .in_valid     (in_valid),
        .in_left      (in_left),
        .in_right     (in_right),
        .out_ready    (out_ready),
        .out_level    (out_level),
        .out_underrun (out_underrun),
        .out_MCLK     (out_MCLK),
        .out_BLCK     (out_BLCK),
        .out_PBLRC    (out_PBLRC),
        .out_PBDAT    (out_PBDAT),
        .out_MUTE     (out_MUTE)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic apply_reset();
        in_en    = 1'b0;
        in_valid = 1'b0;
        @(negedge in_clk);
        in_rst_n = 1'b0;
        repeat (2) @(negedge in_clk);
        in_rst_n = 1'b1;
        @(negedge in_clk);
    endtask

    task automatic push_frame(input logic [BPS-1:0] l, input logic [BPS-1:0] r);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        @(negedge in_clk);
        in_valid = 1'b0;
    endtask

    task automatic capture(input int nbits, output logic [127:0] dat,
                           output logic [127:0] lrc, output int urn, output bit ok);
        logic prev;
        int   got;
        int   cyc;
        dat  = '0;
        lrc  = '0;
        urn  = 0;
        got  = 0;
        cyc  = 0;
        prev = out_BLCK;
        while ((got < nbits) && (cyc < nbits * 8 + 64)) begin
            @(negedge in_clk);
            cyc++;
            if (out_underrun === 1'b1) urn++;
            if ((prev === 1'b0) && (out_BLCK === 1'b1)) begin
                dat = {dat[126:0], out_PBDAT};
                lrc = {lrc[126:0], out_PBLRC};
                got++;
            end
            prev = out_BLCK;
        end
        ok = (got == nbits);
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        @(negedge in_clk);
        in_rst_n = 1'b0;
        @(negedge in_clk);
        checks++; if (out_BLCK !== 1'b1) $display("[TB] FAIL reset_blck: got %b expected 1", out_BLCK); else passed++;
        checks++; if (out_PBLRC !== 1'b1) $display("[TB] FAIL reset_pblrc: got %b expected 1", out_PBLRC); else passed++;
        checks++; if (out_PBDAT !== 1'b0) $display("[TB] FAIL reset_pbdat: got %b expected 0", out_PBDAT); else passed++;
        checks++; if (out_MUTE !== 1'b0) $display("[TB] FAIL reset_mute: got %b expected 0", out_MUTE); else passed++;
        checks++; if (out_MCLK !== 1'b0) $display("[TB] FAIL reset_mclk: got %b expected 0", out_MCLK); else passed++;
        checks++; if (out_level !== 3'd0) $display("[TB] FAIL reset_level: got %0d expected 0", out_level); else passed++;
        checks++; if (out_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", out_ready); else passed++;
        checks++; if (out_underrun !== 1'b0) $display("[TB] FAIL reset_underrun: got %b expected 0", out_underrun); else passed++;
        in_rst_n = 1'b1;
        @(negedge in_clk);
    endtask

    task automatic test_lj();
        logic [127:0] dat;
        logic [127:0] lrc;
        int           urn;
        bit           ok;
        logic         m1;
        apply_reset();
        in_mode = 2'd1;
        push_frame(24'hABCDEF, 24'h123456);
        checks++; if (out_level !== 3'd1) $display("[TB] FAIL lj_level_after_push: got %0d expected 1", out_level); else passed++;
        in_en = 1'b1;
        @(negedge in_clk);
        in_mode = 2'd0;
        capture(64, dat, lrc, urn, ok);
        checks++; if (!ok) $display("[TB] FAIL lj_capture_timeout: got timeout expected 64 bits"); else passed++;
        checks++; if (dat[63:0] !== {24'hABCDEF, 8'h00, 24'h123456, 8'h00})
            $display("[TB] FAIL lj_data: got %h expected %h", dat[63:0], {24'hABCDEF, 8'h00, 24'h123456, 8'h00}); else passed++;
        checks++; if (lrc[63:0] !== {32'hFFFF_FFFF, 32'h0000_0000})
            $display("[TB] FAIL lj_lrclk: got %h expected %h", lrc[63:0], {32'hFFFF_FFFF, 32'h0000_0000}); else passed++;
        checks++; if (urn !== 0) $display("[TB] FAIL lj_underrun: got %0d expected 0", urn); else passed++;
        checks++; if (out_MUTE !== 1'b1) $display("[TB] FAIL lj_mute_run: got %b expected 1", out_MUTE); else passed++;
        m1 = out_MCLK;
        @(negedge in_clk);
        checks++; if (out_MCLK !== ~m1) $display("[TB] FAIL lj_mclk_toggle: got %b expected %b", out_MCLK, ~m1); else passed++;
    endtask

    task automatic test_i2s();
        logic [127:0] dat;
        logic [127:0] lrc;
        int           urn;
        bit           ok;
        apply_reset();
        in_mode = 2'd0;
        push_frame(24'hABCDEF, 24'h123456);
        in_en = 1'b1;
        capture(64, dat, lrc, urn, ok);
        checks++; if (!ok) $display("[TB] FAIL i2s_capture_timeout: got timeout expected 64 bits"); else passed++;
        checks++; if (dat[63:0] !== {1'b0, 24'hABCDEF, 7'd0, 1'b0, 24'h123456, 7'd0})
            $display("[TB] FAIL i2s_data: got %h expected %h", dat[63:0], {1'b0, 24'hABCDEF, 7'd0, 1'b0, 24'h123456, 7'd0}); else passed++;
        checks++; if (lrc[63:0] !== {32'h0000_0000, 32'hFFFF_FFFF})
            $display("[TB] FAIL i2s_lrclk: got %h expected %h", lrc[63:0], {32'h0000_0000, 32'hFFFF_FFFF}); else passed++;
    endtask

    task automatic test_rj();
        logic [127:0] dat;
        logic [127:0] lrc;
        int           urn;
        bit           ok;
        apply_reset();
        in_mode = 2'd2;
        push_frame(24'h000001, 24'h800000);
        in_en = 1'b1;
        capture(64, dat, lrc, urn, ok);
        checks++; if (!ok) $display("[TB] FAIL rj_capture_timeout: got timeout expected 64 bits"); else passed++;
        checks++; if (dat[63:0] !== {8'h00, 24'h000001, 8'h00, 24'h800000})
            $display("[TB] FAIL rj_data: got %h expected %h", dat[63:0], {8'h00, 24'h000001, 8'h00, 24'h800000}); else passed++;
        checks++; if (dat[32] !== 1'b1) $display("[TB] FAIL rj_left_k31: got %b expected 1", dat[32]); else passed++;
        checks++; if (lrc[63:0] !== {32'hFFFF_FFFF, 32'h0000_0000})
            $display("[TB] FAIL rj_lrclk: got %h expected %h", lrc[63:0], {32'hFFFF_FFFF, 32'h0000_0000}); else passed++;
    endtask

    task automatic test_underrun();
        logic [127:0] dat;
        logic [127:0] lrc;
        int           urn;
        bit           ok;
        apply_reset();
        in_mode = 2'd1;
        in_en   = 1'b1;
        capture(128, dat, lrc, urn, ok);
        checks++; if (!ok) $display("[TB] FAIL underrun_capture_timeout: got timeout expected 128 bits"); else passed++;
        checks++; if (dat !== 128'd0) $display("[TB] FAIL underrun_data: got %h expected 0", dat); else passed++;
        checks++; if (urn !== 2) $display("[TB] FAIL underrun_pulses: got %0d expected 2", urn); else passed++;
        checks++; if (out_level !== 3'd0) $display("[TB] FAIL underrun_level: got %0d expected 0", out_level); else passed++;
    endtask

    task automatic test_fifo_full_stop();
        logic [127:0] dat;
        logic [127:0] lrc;
        logic [63:0]  exp_f1;
        int           urn;
        bit           ok;
        int           cyc;
        apply_reset();
        in_mode = 2'd1;
        push_frame(24'h111111, 24'h222222);
        push_frame(24'hA5A5A5, 24'h5A5A5A);
        push_frame(24'h333333, 24'h444444);
        checks++; if (out_ready !== 1'b1) $display("[TB] FAIL full_ready_at3: got %b expected 1", out_ready); else passed++;
        push_frame(24'h555555, 24'h666666);
        checks++; if (out_ready !== 1'b0) $display("[TB] FAIL full_ready_at4: got %b expected 0", out_ready); else passed++;
        checks++; if (out_level !== 3'd4) $display("[TB] FAIL full_level_at4: got %0d expected 4", out_level); else passed++;
        push_frame(24'h777777, 24'h888888);
        checks++; if (out_level !== 3'd4) $display("[TB] FAIL full_level_reject: got %0d expected 4", out_level); else passed++;

        in_en = 1'b1;
        capture(64, dat, lrc, urn, ok);
        checks++; if (!ok || (dat[63:0] !== {24'h111111, 8'h00, 24'h222222, 8'h00}))
            $display("[TB] FAIL full_first_frame: got %h expected %h", dat[63:0], {24'h111111, 8'h00, 24'h222222, 8'h00}); else passed++;

        capture(10, dat, lrc, urn, ok);
        in_en = 1'b0;
        capture(54, dat, lrc, urn, ok);
        exp_f1 = {24'hA5A5A5, 8'h00, 24'h5A5A5A, 8'h00};
        checks++; if (!ok || (dat[53:0] !== exp_f1[53:0]))
            $display("[TB] FAIL stop_frame_completes: got %h expected %h", dat[53:0], exp_f1[53:0]); else passed++;

        cyc = 0;
        while ((out_MUTE !== 1'b0) && (cyc < 100)) begin
            @(negedge in_clk);
            cyc++;
        end
        checks++; if (out_MUTE !== 1'b0) $display("[TB] FAIL stop_mute: got %b expected 0", out_MUTE); else passed++;
        repeat (300) @(negedge in_clk);
        checks++; if (out_level !== 3'd2) $display("[TB] FAIL stop_level: got %0d expected 2", out_level); else passed++;
        checks++; if (out_BLCK !== 1'b1) $display("[TB] FAIL stop_blck: got %b expected 1", out_BLCK); else passed++;
        checks++; if (out_PBDAT !== 1'b0) $display("[TB] FAIL stop_pbdat: got %b expected 0", out_PBDAT); else passed++;
        checks++; if (out_MUTE !== 1'b0) $display("[TB] FAIL stop_stays_idle: got %b expected 0", out_MUTE); else passed++;
        checks++; if (out_ready !== 1'b1) $display("[TB] FAIL stop_ready: got %b expected 1", out_ready); else passed++;
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        in_mode = 2'd1;
        push_frame(24'hABCDEF, 24'h123456);
        push_frame(24'h0F0F0F, 24'hF0F0F0);
        in_en = 1'b1;
        repeat (200) @(negedge in_clk);
        checks++; if (out_MUTE !== 1'b1) $display("[TB] FAIL midrun_mute_before: got %b expected 1", out_MUTE); else passed++;
        checks++; if (out_PBLRC !== 1'b0) $display("[TB] FAIL midrun_pblrc_before: got %b expected 0", out_PBLRC); else passed++;
        checks++; if (out_PBDAT !== 1'b1) $display("[TB] FAIL midrun_pbdat_before: got %b expected 1", out_PBDAT); else passed++;
        checks++; if (out_level !== 3'd1) $display("[TB] FAIL midrun_level_before: got %0d expected 1", out_level); else passed++;
        in_rst_n = 1'b0;
        #1;
        checks++; if (out_BLCK !== 1'b1) $display("[TB] FAIL midrun_blck: got %b expected 1", out_BLCK); else passed++;
        checks++; if (out_PBLRC !== 1'b1) $display("[TB] FAIL midrun_pblrc: got %b expected 1", out_PBLRC); else passed++;
        checks++; if (out_PBDAT !== 1'b0) $display("[TB] FAIL midrun_pbdat: got %b expected 0", out_PBDAT); else passed++;
        checks++; if (out_MUTE !== 1'b0) $display("[TB] FAIL midrun_mute: got %b expected 0", out_MUTE); else passed++;
        checks++; if (out_level !== 3'd0) $display("[TB] FAIL midrun_level: got %0d expected 0", out_level); else passed++;
        checks++; if (out_ready !== 1'b1) $display("[TB] FAIL midrun_ready: got %b expected 1", out_ready); else passed++;
        in_en = 1'b0;
        @(negedge in_clk);
        in_rst_n = 1'b1;
        @(negedge in_clk);
    endtask

    initial begin
        test_reset();
        test_lj();
        test_i2s();
        test_rj();
        test_underrun();
        test_fifo_full_stop();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
